// File: rtl/counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter_bank                                               |
// | Description : Bank of NCH independent up/down counters, each with its    |
// |               own reloadable prescaler, wrap/saturate limit handling,    |
// |               registered zero/compare flags and a one-cycle wrap pulse.  |
// | Ports       : sys_clk, reset (async, active-high)                        |
// |               div_load  [NCH*DIV_W] prescaler reload per channel         |
// |               ch_clr/ch_up/ch_down/ch_auto/ch_dir/ch_sat [NCH] controls  |
// |               cmp_val   [NCH*WIDTH] compare value per channel            |
// |               count     [NCH*WIDTH] registered counter values            |
// |               tick/eq_zero/eq_cmp/wrap [NCH] registered status           |
// | Options     : COUNTER_BANK_SNAPSHOT_EN adds input snap and output        |
// |               snap_count [NCH*WIDTH] (simultaneous capture of counts).   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module counter_bank #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [NCH*DIV_W-1:0]   div_load,
  input  logic [NCH-1:0]         ch_clr,
  input  logic [NCH-1:0]         ch_up,
  input  logic [NCH-1:0]         ch_down,
  input  logic [NCH-1:0]         ch_auto,
  input  logic [NCH-1:0]         ch_dir,
  input  logic [NCH-1:0]         ch_sat,
  input  logic [NCH*WIDTH-1:0]   cmp_val,
`ifdef COUNTER_BANK_SNAPSHOT_EN
  input  logic                   snap,
  output logic [NCH*WIDTH-1:0]   snap_count,
`endif
  output logic [NCH*WIDTH-1:0]   count,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         eq_zero,
  output logic [NCH-1:0]         eq_cmp,
  output logic [NCH-1:0]         wrap
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] div_r;
    logic             tick_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt;
    logic             inc;
    logic             dec;
    logic             wrap_evt_nxt;
    logic             wrap_evt_r;
    logic             eqz_r;
    logic             eqc_r;
    logic             wrap_r;

    // Step decode: clear dominates, a single manual step beats auto, and
    // up+down together cancel (auto is suppressed for that cycle too).
    always_comb begin
      inc = 1'b0;
      dec = 1'b0;
      if (!ch_clr[i]) begin
        if (ch_up[i] ^ ch_down[i]) begin
          inc = ch_up[i];
          dec = ch_down[i];
        end else if (!ch_up[i] && ch_auto[i] && tick_r) begin
          inc = !ch_dir[i];
          dec = ch_dir[i];
        end
      end
    end

    always_comb begin
      cnt_nxt      = cnt_r;
      wrap_evt_nxt = 1'b0;
      if (ch_clr[i]) begin
        cnt_nxt = '0;
      end else if (inc) begin
        if (cnt_r == '1) begin
          if (!ch_sat[i]) begin
            cnt_nxt      = '0;
            wrap_evt_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_r + WIDTH'(1);
        end
      end else if (dec) begin
        if (cnt_r == '0) begin
          if (!ch_sat[i]) begin
            cnt_nxt      = '1;
            wrap_evt_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_r - WIDTH'(1);
        end
      end
    end

    // wrap_evt_r marks the cycle the wrapped value is visible on count;
    // the wrap output follows one cycle later, in step with eq_zero.
    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        div_r      <= '0;
        tick_r     <= 1'b0;
        cnt_r      <= '0;
        eqz_r      <= 1'b0;
        eqc_r      <= 1'b0;
        wrap_evt_r <= 1'b0;
        wrap_r     <= 1'b0;
      end else begin
        if (div_r == '0) begin
          div_r  <= div_load[i*DIV_W +: DIV_W];
          tick_r <= 1'b1;
        end else begin
          div_r  <= div_r - DIV_W'(1);
          tick_r <= 1'b0;
        end
        cnt_r      <= cnt_nxt;
        eqz_r      <= (cnt_r == '0);
        eqc_r      <= (cnt_r == cmp_val[i*WIDTH +: WIDTH]);
        wrap_evt_r <= wrap_evt_nxt;
        wrap_r     <= wrap_evt_r;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_r;
    assign tick[i]                 = tick_r;
    assign eq_zero[i]              = eqz_r;
    assign eq_cmp[i]               = eqc_r;
    assign wrap[i]                 = wrap_r;
  end

`ifdef COUNTER_BANK_SNAPSHOT_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      snap_count <= '0;
    end else if (snap) begin
      snap_count <= count;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`timescale 1ns/1ps
module tb_counter_bank;
  localparam int NCH   = 2;
  localparam int WIDTH = 8;
  localparam int DIV_W = 24;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 sys_clk = 1'b0;
  logic                 reset   = 1'b1;
  logic [NCH*DIV_W-1:0] div_load = '0;
  logic [NCH-1:0]       ch_clr = '0, ch_up = '0, ch_down = '0;
  logic [NCH-1:0]       ch_auto = '0, ch_dir = '0, ch_sat = '0;
  logic [NCH*WIDTH-1:0] cmp_val = '0;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       tick, eq_zero, eq_cmp, wrap;
`ifdef COUNTER_BANK_SNAPSHOT_EN
  logic                 snap = 1'b0;
  logic [NCH*WIDTH-1:0] snap_count;
`endif

  counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .div_load(div_load),
    .ch_clr(ch_clr), .ch_up(ch_up), .ch_down(ch_down), .ch_auto(ch_auto),
    .ch_dir(ch_dir), .ch_sat(ch_sat), .cmp_val(cmp_val),
`ifdef COUNTER_BANK_SNAPSHOT_EN
    .snap(snap), .snap_count(snap_count),
`endif
    .count(count), .tick(tick), .eq_zero(eq_zero), .eq_cmp(eq_cmp), .wrap(wrap)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: integer arithmetic over the counting rules.
  int mcount [NCH];
  int mdiv   [NCH];
  bit mtick  [NCH];
  bit meqz   [NCH];
  bit meqc   [NCH];
  bit mwev   [NCH];
  bit mwrap  [NCH];
`ifdef COUNTER_BANK_SNAPSHOT_EN
  int msnap  [NCH];
`endif

  always @(posedge sys_clk) begin : model
    int c, n, d;
    bit w;
    for (int ch = 0; ch < NCH; ch++) begin
      if (reset) begin
        mcount[ch] = 0; mdiv[ch] = 0; mtick[ch] = 0; meqz[ch] = 0;
        meqc[ch] = 0; mwev[ch] = 0; mwrap[ch] = 0;
`ifdef COUNTER_BANK_SNAPSHOT_EN
        msnap[ch] = 0;
`endif
      end else begin
        c = mcount[ch];
        d = 0;
        w = 0;
        if (ch_clr[ch]) begin
          n = 0;
        end else begin
          if (ch_up[ch] != ch_down[ch]) d = ch_up[ch] ? 1 : -1;
          else if (!ch_up[ch] && ch_auto[ch] && mtick[ch]) d = ch_dir[ch] ? -1 : 1;
          n = c + d;
          if (n > MAXV || n < 0) begin
            if (ch_sat[ch]) n = c;
            else begin
              n = (n + MAXV + 1) % (MAXV + 1);
              w = 1;
            end
          end
        end
`ifdef COUNTER_BANK_SNAPSHOT_EN
        if (snap) msnap[ch] = c;
`endif
        mwrap[ch] = mwev[ch];
        mwev[ch]  = w;
        meqz[ch]  = (c == 0);
        meqc[ch]  = (c == int'(cmp_val[ch*WIDTH +: WIDTH]));
        if (mdiv[ch] == 0) begin
          mdiv[ch]  = int'(div_load[ch*DIV_W +: DIV_W]);
          mtick[ch] = 1;
        end else begin
          mdiv[ch]  = mdiv[ch] - 1;
          mtick[ch] = 0;
        end
        mcount[ch] = n;
      end
    end
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("model count[%0d]", ch), longint'(count[ch*WIDTH +: WIDTH]), longint'(mcount[ch]));
      chk($sformatf("model tick[%0d]", ch), longint'(tick[ch]), longint'(mtick[ch]));
      chk($sformatf("model eq_zero[%0d]", ch), longint'(eq_zero[ch]), longint'(meqz[ch]));
      chk($sformatf("model eq_cmp[%0d]", ch), longint'(eq_cmp[ch]), longint'(meqc[ch]));
      chk($sformatf("model wrap[%0d]", ch), longint'(wrap[ch]), longint'(mwrap[ch]));
`ifdef COUNTER_BANK_SNAPSHOT_EN
      chk($sformatf("model snap_count[%0d]", ch), longint'(snap_count[ch*WIDTH +: WIDTH]), longint'(msnap[ch]));
`endif
    end
  end

  task automatic pulse(input int which);
    // which: 0=clr, 1=up, 2=down on channel 0, one cycle
    @(negedge sys_clk);
    case (which)
      0: ch_clr[0] = 1'b1;
      1: ch_up[0] = 1'b1;
      default: ch_down[0] = 1'b1;
    endcase
    @(negedge sys_clk);
    ch_clr[0] = 1'b0; ch_up[0] = 1'b0; ch_down[0] = 1'b0;
  endtask

  task automatic post_edge();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    div_load[0*DIV_W +: DIV_W] = 24'd3;
    div_load[1*DIV_W +: DIV_W] = 24'd2;
    ch_auto = 2'b11;
    cmp_val[0 +: WIDTH] = 8'h80;
    cmp_val[WIDTH +: WIDTH] = 8'h05;
    #2;
    chk("reset count", longint'(count), 0);
    chk("reset flags", longint'({tick, eq_zero, eq_cmp, wrap}), 0);

    // Release, first tick and eq_zero on the first edge.
    @(negedge sys_clk); reset = 1'b0;
    post_edge();
    chk("first tick", longint'(tick), 3);
    chk("first eq_zero", longint'(eq_zero), 3);
    // Ten edges in: ch0 (period 4) and ch1 (period 3) both reached 3.
    repeat (8) @(posedge sys_clk);
    post_edge();
    chk("auto ch0 count", longint'(count[0 +: WIDTH]), 3);
    chk("auto ch1 count", longint'(count[WIDTH +: WIDTH]), 3);

    // Wrap at max in wrap mode.
    @(negedge sys_clk); ch_auto = 2'b00;
    pulse(0);
    pulse(2);
    repeat (3) @(negedge sys_clk);
    chk("down wrap to FF", longint'(count[0 +: WIDTH]), 'hFF);
    ch_up[0] = 1'b1;
    post_edge();
    chk("up wrap count", longint'(count[0 +: WIDTH]), 0);
    chk("wrap not yet", longint'(wrap[0]), 0);
    @(negedge sys_clk); ch_up[0] = 1'b0;
    post_edge();
    chk("wrap pulse", longint'(wrap[0]), 1);
    chk("eq_zero after wrap", longint'(eq_zero[0]), 1);
    post_edge();
    chk("wrap one cycle", longint'(wrap[0]), 0);

    // Saturation at both limits.
    pulse(2);
    repeat (3) @(negedge sys_clk);
    ch_sat[0] = 1'b1;
    pulse(1);
    chk("sat hold FF", longint'(count[0 +: WIDTH]), 'hFF);
    post_edge();
    chk("sat no wrap a", longint'(wrap[0]), 0);
    post_edge();
    chk("sat no wrap b", longint'(wrap[0]), 0);
    pulse(0);
    pulse(2);
    chk("sat hold 0", longint'(count[0 +: WIDTH]), 0);
    post_edge();
    post_edge();
    chk("sat no wrap c", longint'(wrap[0]), 0);

    // Priority: clear over up and tick; up+down holds.
    @(negedge sys_clk);
    ch_sat[0] = 1'b0;
    div_load[0 +: DIV_W] = 24'd0;
    ch_auto[0] = 1'b1;
    repeat (6) @(negedge sys_clk);
    ch_clr[0] = 1'b1; ch_up[0] = 1'b1;
    post_edge();
    chk("clr priority", longint'(count[0 +: WIDTH]), 0);
    @(negedge sys_clk); ch_clr[0] = 1'b0; ch_up[0] = 1'b0;
    repeat (3) @(negedge sys_clk);
    ch_up[0] = 1'b1; ch_down[0] = 1'b1;
    post_edge();
    chk("up+down hold", longint'(count[0 +: WIDTH]), 3);
    @(negedge sys_clk); ch_up[0] = 1'b0; ch_down[0] = 1'b0;

    // Compare flag from 7F counting into 80.
    ch_auto[0] = 1'b0;
    pulse(0);
    ch_up[0] = 1'b1;
    repeat (127) @(negedge sys_clk);
    ch_up[0] = 1'b0;
    chk("reach 7F", longint'(count[0 +: WIDTH]), 'h7F);
    ch_auto[0] = 1'b1;
    post_edge();
    chk("count 80", longint'(count[0 +: WIDTH]), 'h80);
    chk("eq_cmp lag", longint'(eq_cmp[0]), 0);
    post_edge();
    chk("eq_cmp set", longint'(eq_cmp[0]), 1);
    post_edge();
    chk("eq_cmp clear", longint'(eq_cmp[0]), 0);
    @(negedge sys_clk); ch_auto[0] = 1'b0;
    chk("ch1 untouched", longint'(count[WIDTH +: WIDTH]), 3);

    // Asynchronous reset mid-count.
    pulse(0);
    ch_up[0] = 1'b1;
    repeat (8'h42) @(negedge sys_clk);
    ch_up[0] = 1'b0;
    chk("reach 42", longint'(count[0 +: WIDTH]), 'h42);
    @(posedge sys_clk); #2; reset = 1'b1; #1;
    chk("async reset count", longint'(count), 0);
    chk("async reset flags", longint'({tick, eq_zero, eq_cmp, wrap}), 0);
    @(negedge sys_clk); @(negedge sys_clk); reset = 1'b0;
    post_edge();
    chk("tick after release", longint'(tick), 3);

    // Randomized traffic checked by the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge sys_clk);
      ch_clr  = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      ch_up   = NCH'($urandom) & NCH'($urandom);
      ch_down = NCH'($urandom) & NCH'($urandom);
      ch_auto = NCH'($urandom);
      if (cyc % 40 == 0) begin
        ch_dir = NCH'($urandom);
        ch_sat = NCH'($urandom);
        for (int ch = 0; ch < NCH; ch++) begin
          div_load[ch*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 3));
          cmp_val[ch*WIDTH +: WIDTH]  = WIDTH'($urandom_range(0, 6));
        end
      end
`ifdef COUNTER_BANK_SNAPSHOT_EN
      snap = 1'($urandom);
`endif
    end

    @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of independent counter channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning counter width in bits (2..32).
REQ-003 SHALL have parameter DIV_W, default 24, meaning prescaler width in bits per channel.
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port div_load  input  NCH*DIV_W  per-channel prescaler reload value; channel i at [i*DIV_W +: DIV_W].
REQ-007 SHALL have port ch_clr  input  NCH  synchronous clear request per channel.
REQ-008 SHALL have port ch_up  input  NCH  single-step increment request per channel.
REQ-009 SHALL have port ch_down  input  NCH  single-step decrement request per channel.
REQ-010 SHALL have port ch_auto  input  NCH  level; enables counting on prescaler tick.
REQ-011 SHALL have port ch_dir  input  NCH  auto-count direction; 0 = up, 1 = down.
REQ-012 SHALL have port ch_sat  input  NCH  1 = saturate at limits, 0 = wrap.
REQ-013 SHALL have port cmp_val  input  NCH*WIDTH  per-channel compare value.
REQ-014 SHALL have port count  output  NCH*WIDTH  registered counter values.
REQ-015 SHALL have port tick  output  NCH  registered prescaler pulse per channel.
REQ-016 SHALL have port eq_zero  output  NCH  registered flag: count was zero on the previous cycle.
REQ-017 SHALL have port eq_cmp  output  NCH  registered flag: count equalled cmp_val on the previous cycle.
REQ-018 SHALL have port wrap  output  NCH  one-cycle pulse: count wrapped on the previous cycle.

Function
REQ-019 Prescaler per channel: div==0 -> div<=div_load, tick<=1; else div<=div-1, tick<=0; tick period = div_load+1 cycles; div_load=0 gives tick every cycle.
REQ-020 Counter update priority per channel: ch_clr -> 0; else ch_up XOR ch_down -> +/-1; else ch_up AND ch_down -> hold (auto ignored that cycle); else ch_auto AND tick -> +/-1 per ch_dir; else hold.
REQ-021 Wrap mode (ch_sat=0): max+1 -> 0 and 0-1 -> max, modulo 2^WIDTH; wrap SHALL pulse for exactly the following cycle.
REQ-022 Saturate mode (ch_sat=1): increment at max and decrement at 0 SHALL hold the value; wrap SHALL NOT pulse.
REQ-023 eq_zero and eq_cmp SHALL be registered compares of the current count, so they lag count by one cycle.
REQ-024 Channels SHALL be fully independent; no control of channel i SHALL affect channel j.
REQ-025 div_load changes SHALL take effect only at the next reload; the running prescaler count SHALL NOT be disturbed.
REQ-026 ch_clr SHALL NOT reset the prescaler.

Reset
REQ-027 Assertion of reset SHALL immediately set count, div, tick, eq_zero, eq_cmp and wrap (and snap_count if present) to 0.
REQ-028 Prescaler: the first tick SHALL be asserted on the first rising edge after reset release; eq_zero SHALL rise on the first edge after release.

Configuration
REQ-029 Macro COUNTER_BANK_SNAPSHOT_EN defined: SHALL add input snap (1) and output snap_count (NCH*WIDTH); on a snap=1 edge all channels' current count values SHALL be captured simultaneously into snap_count, held otherwise.
REQ-030 Macro COUNTER_BANK_SNAPSHOT_EN undefined: snap and snap_count SHALL be absent; all other behaviour identical.

Verification
REQ-031 NCH=2, WIDTH=8, div_load=3, ch_auto=1, ch_dir=0 -> tick every 4 cycles; count +1 per tick.
REQ-032 count=8'hFF, ch_sat=0, ch_up pulse -> count=8'h00 next cycle, wrap=1 one cycle later, eq_zero=1 one cycle later.
REQ-033 count=8'hFF, ch_sat=1, ch_up pulse -> count stays 8'hFF, wrap stays 0; count=0, ch_down -> stays 0.
REQ-034 ch_clr, ch_up and tick all asserted on the same cycle -> count=0; ch_up and ch_down together -> count unchanged.
REQ-035 cmp_val=8'h80, auto count from 8'h7F -> eq_cmp=1 exactly one cycle after count=8'h80; channel 1 unaffected by channel 0 controls.
REQ-036 Reset asserted mid-count (count=8'h42) -> all outputs 0 without clock edge; first tick on first edge after release.
